// File: rtl/rgb2gray_fifo_writer_if.sv
// Stream and FIFO-write signal bundle for rgb2gray_fifo_writer.
// master = the converter block, slave = source/FIFO environment.
interface rgb2gray_fifo_writer_if #(
  parameter int PIXEL_SIZE = 8,
  parameter int IMG_WIDTH  = 640
);
  logic                          rgb_valid;
  logic                          rgb_ready;
  logic [3*PIXEL_SIZE-1:0]       rgb_data;
  logic                          cnv_avr_fifo_wr_en;
  logic [PIXEL_SIZE-1:0]         cnv_avr_fifo_wr_data;
  logic                          cnv_avr_fifo_full;
  logic                          cnv_avr_wr_ack;
  logic [$clog2(IMG_WIDTH):0]    cnv_avr_fifo_data_count;

  modport master (
    input  rgb_valid, rgb_data, cnv_avr_fifo_full, cnv_avr_wr_ack, cnv_avr_fifo_data_count,
    output rgb_ready, cnv_avr_fifo_wr_en, cnv_avr_fifo_wr_data
  );

  modport slave (
    output rgb_valid, rgb_data, cnv_avr_fifo_full, cnv_avr_wr_ack, cnv_avr_fifo_data_count,
    input  rgb_ready, cnv_avr_fifo_wr_en, cnv_avr_fifo_wr_data
  );
endinterface

// File: rtl/rgb2gray_fifo_writer.sv
// RGB->gray converter writing into the gray FIFO with credit-based input throttling.
// Optional GRAY_ROUND_EN selects round-to-nearest instead of truncation.
module rgb2gray_fifo_writer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_LENGTH = 640,
  parameter int PIXEL_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  rgb2gray_fifo_writer_if.master bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   wr_drop_err
);
  localparam int COEF_W = 8;
  localparam int SUM_W  = 2 * PIXEL_SIZE;
  localparam int CNT_W  = $clog2(IMG_WIDTH) + 1;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;

  localparam logic [COEF_W-1:0] COEF_R = COEF_W'(77);
  localparam logic [COEF_W-1:0] COEF_G = COEF_W'(150);
  localparam logic [COEF_W-1:0] COEF_B = COEF_W'(29);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_LENGTH - 1);
  localparam logic [CNT_W:0]    CREDIT_LIM = (CNT_W + 1)'(IMG_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic [1:0]              inflight, inflight_nxt;
  logic [CNT_W:0]          credit_sum;
  logic                    accept;
  logic                    last_pix;
  logic                    vld_p1, vld_p2, vld_p3;
  logic [SUM_W-1:0]        sum_p1;
  logic [PIXEL_SIZE-1:0]   gray_p2;

  function automatic logic [SUM_W-1:0] luma_sum(input logic [3*PIXEL_SIZE-1:0] rgb);
    logic [SUM_W-1:0] r, g, b;
    r = SUM_W'(rgb[3*PIXEL_SIZE-1 -: PIXEL_SIZE]);
    g = SUM_W'(rgb[2*PIXEL_SIZE-1 -: PIXEL_SIZE]);
    b = SUM_W'(rgb[PIXEL_SIZE-1:0]);
    return r * SUM_W'(COEF_R) + g * SUM_W'(COEF_G) + b * SUM_W'(COEF_B);
  endfunction

  function automatic logic [PIXEL_SIZE-1:0] scale_gray(input logic [SUM_W-1:0] s);
`ifdef GRAY_ROUND_EN
    return PIXEL_SIZE'((s + SUM_W'(1 << (PIXEL_SIZE - 1))) >> PIXEL_SIZE);
`else
    return PIXEL_SIZE'(s >> PIXEL_SIZE);
`endif
  endfunction

  assign credit_sum = {1'b0, bus.cnv_avr_fifo_data_count} + (CNT_W + 1)'(inflight);
  assign accept     = bus.rgb_valid && bus.rgb_ready;
  assign last_pix   = (col == COL_LAST) && (row == ROW_LAST);

  // The write for a pixel leaves inflight one cycle after wr_en, acked or not.
  always_comb begin
    inflight_nxt = inflight;
    case ({accept, vld_p3})
      2'b10:   inflight_nxt = inflight + 2'd1;
      2'b01:   inflight_nxt = inflight - 2'd1;
      default: inflight_nxt = inflight;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ACTIVE;
      S_ACTIVE: if (accept && last_pix) state_nxt = S_FLUSH;
      S_FLUSH:  if (inflight_nxt == 2'd0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    frame_done    = (state == S_DONE);
    bus.rgb_ready = (state == S_ACTIVE) && !bus.cnv_avr_fifo_full && (credit_sum < CREDIT_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col         <= '0;
      row         <= '0;
      inflight    <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      vld_p3      <= 1'b0;
      wr_drop_err <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      vld_p1   <= accept;
      vld_p2   <= vld_p1;
      vld_p3   <= vld_p2;
      if (vld_p3 && !bus.cnv_avr_wr_ack) wr_drop_err <= 1'b1;
      if (state == S_IDLE && start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage 1: weighted channel sum
  always_ff @(posedge clk) begin
    if (accept) sum_p1 <= luma_sum(bus.rgb_data);
  end

  // Stage 2: scaled gray value presented to the FIFO
  always_ff @(posedge clk) begin
    if (rst_n)       gray_p2 <= '0;
    else if (vld_p1) gray_p2 <= scale_gray(sum_p1);
  end

  assign bus.cnv_avr_fifo_wr_en   = vld_p2;
  assign bus.cnv_avr_fifo_wr_data = gray_p2;
endmodule

// File: tb/tb_rgb2gray_fifo_writer.sv
// Directed bench for rgb2gray_fifo_writer on a 4x2 frame; honours GRAY_ROUND_EN.
module tb_rgb2gray_fifo_writer;
  localparam int W = 4;
  localparam int L = 2;
  localparam int P = 8;

  logic clk = 1'b0;
  logic rst_n, start, busy, frame_done, wr_drop_err;
  int   total = 0, bad = 0;
  int   wr_cnt = 0, full_viol = 0, fd_cnt = 0;
  int   wr_seen = 0, drop_idx = -1;

  rgb2gray_fifo_writer_if #(.PIXEL_SIZE(P), .IMG_WIDTH(W)) bus ();

  rgb2gray_fifo_writer #(.IMG_WIDTH(W), .IMG_LENGTH(L), .PIXEL_SIZE(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done), .wr_drop_err(wr_drop_err)
  );

  always #5 clk = ~clk;

  // FIFO ack model: acks every write one cycle later except the selected one.
  always @(posedge clk) begin
    if (bus.cnv_avr_fifo_wr_en) begin
      bus.cnv_avr_wr_ack <= (wr_seen != drop_idx);
      wr_seen <= wr_seen + 1;
    end else begin
      bus.cnv_avr_wr_ack <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.cnv_avr_fifo_wr_en) begin
      wr_cnt++;
      if (bus.cnv_avr_fifo_full) full_viol++;
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  exp_trunc;
    logic [7:0]  exp_round;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] expected(input int i);
`ifdef GRAY_ROUND_EN
    return vecs[i].exp_round;
`else
    return vecs[i].exp_trunc;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input logic [23:0] d, input int n, output int got);
    bus.rgb_valid = 1'b1;
    bus.rgb_data  = d;
    got = 0;
    for (int c = 0; c < 60 && got < n; c++) begin
      #1;
      if (bus.rgb_ready) got++;
      tick();
    end
    bus.rgb_valid = 1'b0;
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int   got, base, fd_base;
    logic seen;

    vecs[0] = '{24'hFF0000, 8'd76,  8'd77};
    vecs[1] = '{24'h00FF00, 8'd149, 8'd149};
    vecs[2] = '{24'h0000FF, 8'd28,  8'd29};
    vecs[3] = '{24'hFFFFFF, 8'd255, 8'd255};
    vecs[4] = '{24'h000000, 8'd0,   8'd0};
    vecs[5] = '{24'h0A141E, 8'd18,  8'd18};
    vecs[6] = '{24'h808080, 8'd128, 8'd128};
    vecs[7] = '{24'hFFFF00, 8'd226, 8'd226};

    rst_n = 1'b1; start = 1'b0;
    bus.rgb_valid = 1'b0; bus.rgb_data = '0;
    bus.cnv_avr_fifo_full = 1'b0; bus.cnv_avr_fifo_data_count = '0;
    tick(); tick();
    chk("rst_ready", 32'(bus.rgb_ready), 0);
    chk("rst_wr_en", 32'(bus.cnv_avr_fifo_wr_en), 0);
    chk("rst_wr_data", 32'(bus.cnv_avr_fifo_wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_drop_err", 32'(wr_drop_err), 0);
    rst_n = 1'b0;
    tick();

    // Frame 1: colour table back-to-back, plus an ignored start mid-frame.
    base = wr_cnt; fd_base = fd_cnt;
    start_frame();
    #1;
    chk("f1_busy_after_start", 32'(busy), 1);
    chk("f1_ready_after_start", 32'(bus.rgb_ready), 1);
    for (int i = 0; i < 10; i++) begin
      bus.rgb_valid = (i < 8);
      bus.rgb_data  = (i < 8) ? vecs[i].rgb : 24'h0;
      start = (i == 4);
      #1;
      if (i < 8) chk($sformatf("f1_ready_%0d", i), 32'(bus.rgb_ready), 1);
      if (i == 8) chk("f1_ready_after_last", 32'(bus.rgb_ready), 0);
      if (i >= 2) begin
        chk($sformatf("f1_wr_en_%0d", i - 2), 32'(bus.cnv_avr_fifo_wr_en), 1);
        chk($sformatf("f1_gray_%0d", i - 2), 32'(bus.cnv_avr_fifo_wr_data), 32'(expected(i - 2)));
      end
      tick();
    end
    start = 1'b0;
    #1;
    chk("f1_wr_en_after_8", 32'(bus.cnv_avr_fifo_wr_en), 0);
    chk("f1_done_early", 32'(frame_done), 0);
    tick(); #1;
    chk("f1_done_at_n4", 32'(frame_done), 1);
    chk("f1_busy_in_done", 32'(busy), 1);
    tick(); #1;
    chk("f1_done_pulse_end", 32'(frame_done), 0);
    chk("f1_busy_low", 32'(busy), 0);
    chk("f1_write_count", 32'(wr_cnt - base), 8);
    chk("f1_done_count", 32'(fd_cnt - fd_base), 1);

    // Frame 2: credit and full backpressure.
    base = wr_cnt;
    bus.cnv_avr_fifo_data_count = (W - 1);
    bus.rgb_valid = 1'b1; bus.rgb_data = vecs[0].rgb;
    start_frame();
    #1;
    chk("f2_ready_one_credit", 32'(bus.rgb_ready), 1);
    tick(); #1;
    chk("f2_ready_no_credit", 32'(bus.rgb_ready), 0);
    bus.cnv_avr_fifo_data_count = W;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("f2_ready_count_full_%0d", c), 32'(bus.rgb_ready), 0);
      tick();
    end
    bus.cnv_avr_fifo_data_count = '0; bus.cnv_avr_fifo_full = 1'b1;
    #1;
    chk("f2_ready_full_flag", 32'(bus.rgb_ready), 0);
    tick();
    bus.cnv_avr_fifo_full = 1'b0;
    #1;
    chk("f2_ready_resumed", 32'(bus.rgb_ready), 1);
    stream(vecs[3].rgb, 7, got);
    chk("f2_accepts", 32'(got), 7);
    wait_done(seen);
    chk("f2_frame_done", 32'(seen), 1);
    tick();
    chk("f2_write_count", 32'(wr_cnt - base), 8);

    // Frame 3: one write left unacknowledged.
    chk("f3_drop_err_before", 32'(wr_drop_err), 0);
    drop_idx = wr_seen + 3;
    start_frame();
    stream(vecs[3].rgb, 8, got);
    chk("f3_accepts", 32'(got), 8);
    wait_done(seen);
    chk("f3_frame_done", 32'(seen), 1);
    chk("f3_drop_err_at_done", 32'(wr_drop_err), 1);
    tick(); #1;
    chk("f3_drop_err_sticky", 32'(wr_drop_err), 1);
    chk("f3_busy_low", 32'(busy), 0);
    drop_idx = -1;

    // Frame 4: reset mid-frame, then a clean restart.
    start_frame();
    stream(vecs[1].rgb, 3, got);
    bus.rgb_valid = 1'b1;
    rst_n = 1'b1;
    tick();
    base = wr_cnt;
    #1;
    chk("mid_rst_ready", 32'(bus.rgb_ready), 0);
    chk("mid_rst_wr_en", 32'(bus.cnv_avr_fifo_wr_en), 0);
    chk("mid_rst_wr_data", 32'(bus.cnv_avr_fifo_wr_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_drop_err", 32'(wr_drop_err), 0);
    tick();
    rst_n = 1'b0; bus.rgb_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("mid_rst_no_writes", 32'(wr_cnt - base), 0);
    base = wr_cnt;
    start_frame();
    stream(vecs[2].rgb, 8, got);
    chk("restart_accepts", 32'(got), 8);
    wait_done(seen);
    chk("restart_frame_done", 32'(seen), 1);
    chk("restart_gray", 32'(bus.cnv_avr_fifo_wr_data), 32'(expected(2)));
    tick();
    chk("restart_write_count", 32'(wr_cnt - base), 8);
    chk("no_write_while_full", 32'(full_viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rgb2gray_fifo_writer.md
# rgb2gray_fifo_writer

Producer side of the grayscale pixel FIFO (`cnv_avr_fifo`) that feeds the averaging filter. It accepts one RGB pixel per cycle on a valid/ready stream and converts it to grayscale in a 2-stage pipeline. It writes each result into the FIFO through the wr_en/wr_data/full/wr_ack/data_count interface, and throttles input by credit so the FIFO is never written while full. It counts one IMG_WIDTH×IMG_LENGTH frame per `start` and signals completion.

## Interface
- `IMG_WIDTH`, 640, pixels per row; equals the gray FIFO depth
- `IMG_LENGTH`, 640, rows per frame
- `PIXEL_SIZE`, 8, bits per colour channel and per gray pixel

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-high (asserted = 1, sampled on `clk`)
- `start`  in  1  arms one frame; honoured only in IDLE
- `rgb_valid`  in  1  source has a pixel
- `rgb_ready`  out  1  block accepts pixel this cycle
- `rgb_data`  in  3*PIXEL_SIZE  {R,G,B}, R in MSBs
- `cnv_avr_fifo_wr_en`  out  1  write strobe to gray FIFO
- `cnv_avr_fifo_wr_data`  out  PIXEL_SIZE  gray pixel
- `cnv_avr_fifo_full`  in  1  FIFO full
- `cnv_avr_wr_ack`  in  1  FIFO write accepted (one cycle after wr_en)
- `cnv_avr_fifo_data_count`  in  $clog2(IMG_WIDTH)+1  FIFO occupancy
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame
- `wr_drop_err`  out  1  sticky: a write was not acknowledged

## Operation
- FSM: IDLE → ACTIVE on `start`. ACTIVE → FLUSH when the last pixel (col=IMG_WIDTH-1, row=IMG_LENGTH-1) is accepted. FLUSH → DONE when `inflight`=0. DONE → IDLE unconditionally; `frame_done`=1 only in DONE.
- Accept = `rgb_valid && rgb_ready`. Increments `col`; at IMG_WIDTH-1 `col` wraps to 0 and `row` increments. Both counters clear on entering ACTIVE.
- `inflight`, 0..3: pixels accepted but not yet acked. +1 on accept, −1 on `cnv_avr_wr_ack`. Simultaneous accept and ack leaves it unchanged.
- `rgb_ready` = ACTIVE && !`cnv_avr_fifo_full` && (`cnv_avr_fifo_data_count` + `inflight` < IMG_WIDTH). Combinational; no dependence on `rgb_valid`.
- Stage 1 registers `sum` = 77·R + 150·G + 29·B, width 2*PIXEL_SIZE bits; max 255·256 = 65280 fits.
- Stage 2 registers `cnv_avr_fifo_wr_data` = `sum` >> 8 (see Configuration) and asserts `cnv_avr_fifo_wr_en` for exactly one cycle per accepted pixel.
- The pipeline never stalls. Credit guarantees FIFO space for every in-flight pixel.
- `wr_drop_err` sets when `cnv_avr_fifo_wr_en` was 1 in the previous cycle and `cnv_avr_wr_ack` is 0 now. It clears only on reset. That pixel is lost and `inflight` is decremented anyway, so the FSM still completes.
- `start` outside IDLE is ignored. `rgb_valid` outside ACTIVE is ignored (`rgb_ready`=0).

## Timing
- Reset values: `rgb_ready`=0, `cnv_avr_fifo_wr_en`=0, `cnv_avr_fifo_wr_data`=0, `busy`=0, `frame_done`=0, `wr_drop_err`=0. FSM=IDLE, counters=0, pipeline valids=0.
- Reset mid-frame: pipeline contents are discarded and no further wr_en is issued. Pixels already in the FIFO are not recalled.
- Latency: pixel accepted at cycle N → `wr_en`/`wr_data` at N+2 → ack expected at N+3.
- Throughput: 1 pixel/cycle while the FIFO drains at ≥1/cycle.
- `start` at cycle N → `busy`=1 and `rgb_ready` may be 1 at N+1.
- Last pixel accepted at cycle N with normal acks → FLUSH N+1..N+3, DONE (frame_done) at N+4, IDLE at N+5.

## Configuration
- `GRAY_ROUND_EN` defined: `wr_data` = (`sum` + 128) >> 8, round-to-nearest. The maximum, 65408 >> 8 = 255, never overflows.
- `GRAY_ROUND_EN` undefined: `wr_data` = `sum` >> 8, truncation.

## Test plan
- Reset: hold `rst_n`=1 for 2 cycles mid-frame → all outputs 0 the next cycle; no wr_en afterwards; `start` then restarts a frame cleanly.
- Colour values, truncation / `GRAY_ROUND_EN`:
  - R=255 only → 76 / 77
  - G=255 only → 149 / 149
  - B=255 only → 28 / 29
  - white → 255 / 255
  - black → 0 / 0
  - each result appears exactly 2 cycles after accept.
- Frame count with IMG_WIDTH=4, IMG_LENGTH=2, FIFO draining continuously → exactly 8 writes, `rgb_ready` low after the 8th accept, a single `frame_done` pulse 4 cycles after the last accept, `busy` low the next cycle.
- Backpressure: `cnv_avr_fifo_data_count`=IMG_WIDTH-1 with `inflight`=0 → one pixel accepted, then `rgb_ready`=0 until data_count drops. With data_count=IMG_WIDTH or `full`=1 → `rgb_ready`=0; no wr_en ever coincides with `full`=1.
- Missing ack: suppress `cnv_avr_wr_ack` for one write → `wr_drop_err`=1 the cycle after, stays 1 through `frame_done`, and the frame still completes.
- `start` pulsed during ACTIVE → ignored; pixel count and `frame_done` timing unchanged.
